fp_conv_sched: RTL and testbench
================================

# fp_conv_sched

Round-robin scheduler that shares a single float-to-fixed unpack datapath among `N_REQ` requesters in the LDA datapath. It accepts IEEE-754 single-precision words over per-requester valid/ready handshakes and pushes them through a 2-stage pipeline around the shared unpack core. It returns sign, a normalised integer mantissa, an unbiased scale exponent and the requester tag on one output stream with backpressure.

## Interface
- `N_REQ`, default 4: number of requesters; legal range is 2..8.
- `TAG_W`, default `$clog2(N_REQ)`: width of the requester tag.
- `clk` in, 1: the single clock; everything is on the rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `req_valid` in, `N_REQ`: per-requester valid.
- `req_data` in, `32*N_REQ`: requester k owns bits `[32k+31:32k]`.
- `req_ready` out, `N_REQ`: one-hot or zero; a transfer happens when valid and ready are both high.
- `out_valid` out, 1: result available.
- `out_ready` in, 1: consumer accepts the result.
- `out_sign` out, 1: input bit 31.
- `out_mant` out, 24: reduced mantissa.
- `out_exp` out, 9: signed two's-complement scale; value = (-1)^sign · mant · 2^exp.
- `out_tag` out, `TAG_W`: index of the source requester.
- `busy` out, 1: any pipeline stage holds valid data.

## Operation
- Unpack function, with input a, e = a[30:23] and f = a[22:0]:
  - If a[30:0] == 0: mant = 0, exp = 0.
  - Otherwise: tz = index of the lowest set bit of f (23 when f == 0); mant = {1, f} >> tz; exp = e − 127 − (23 − tz), computed in 10 bits and truncated to 9.
  - e == 0 and e == 255 are not special-cased (the implicit 1 is always applied).
- Pipeline:
  - S1 is the capture register: data, tag and v1.
  - The combinational unpack core sits between S1 and S2.
  - S2 is the output register: sign, mant, exp, tag and v2 = `out_valid`.
- Advance rule:
  - adv2 = !v2 | out_ready.
  - adv1 = !v1 | adv2.
  - S2 loads from the core (v2 ← v1) when adv2; S1 loads when adv1.
- Arbitration, evaluated every cycle:
  - Starting at pointer `rr`, the grant goes to the first k in `rr`, `rr`+1, … (mod `N_REQ`) with `req_valid[k]` high.
  - `req_ready[k]` = grant[k] & adv1. At most one ready is high; none is high if no request is valid.
- On an accepted transfer, S1 ← {`req_data[k]`, k}, v1 ← 1, and `rr` ← (k+1) mod `N_REQ`.
- When adv1 is high and there is no grant, v1 ← 0. When adv1 is low, S1 holds and `rr` holds.
- Data-hold rule: a requester that drops valid without being granted loses nothing and is not penalised. Requesters must keep data stable while valid is high and ready is low.
- Reset: v1 = v2 = 0, `rr` = 0, and all output data fields are 0. Resulting outputs: `out_valid` = 0, `req_ready` = 0, `busy` = 0.
- Reset mid-operation flushes both stages. In-flight data is discarded, with no partial output.

## Timing
- Latency: a transfer accepted at edge n gives `out_valid` high after edge n+1 (result visible in cycle n+1, 2 registers deep).
- Throughput: 1 transfer per cycle while `out_ready` = 1.
- Backpressure:
  - With `out_ready` = 0 and v2 = 1, S2 holds.
  - S1 still fills if it is empty (1 more accept), after which all `req_ready` = 0.
  - Output fields are stable while `out_valid` is high and `out_ready` is low.
- Simultaneous pop of S2 and accept into S1 in the same cycle is legal: full rate with no bubble.
- `req_ready` depends combinationally on `req_valid` and `out_ready`. `out_*` are registered only.
- Fairness: with all requesters continuously valid, grants cycle 0,1,…,`N_REQ`−1. Worst-case wait is `N_REQ`−1 grants.

## Structure
- Package `fp_conv_pkg` holds:
  - `FRAC_W`=23, `MANT_W`=24, `EXP_W`=9, `EXP_BIAS`=127.
  - A packed struct `conv_res_t` {sign, mant, exp}.
- Sub-module `fp_unpack_core` is combinational: 32-bit input to `conv_res_t`, containing the tz priority encoder and the shift.
- The scheduler holds the arbiter, `rr`, S1 and S2.

## Test plan
- Single request: requester 2 sends `0x3F800000` → next cycle sign=0, mant=`0x000001`, exp=0, tag=2.
- Values: `0x3FC00000` → mant 3, exp −1 (`0x1FF`); `0xC0C00000` → sign 1, mant 3, exp 1; `0x80000000` → sign 1, mant 0, exp 0.
- Round-robin: all 4 requesters valid continuously with `out_ready`=1 → tags 0,1,2,3,0,… on consecutive cycles with no bubbles.
- Backpressure: hold `out_ready`=0 for 5 cycles with requesters 0 and 1 valid → exactly one extra accept, then `req_ready`=0 and outputs stable. On release, results drain in order with no loss or duplication.
- Reset mid-stream: assert `rst` while v1 = v2 = 1 → next cycle `out_valid`=0, `busy`=0, and the first grant afterwards goes to requester 0.
- Randomised: random valid/ready patterns against a reference model of the unpack formula → every accepted word appears exactly once, with the correct tag and per-requester order.

Source files
------------

// File: rtl/fp_conv_pkg.sv
// Shared definitions for the float-to-fixed conversion scheduler.
//   FRAC_W / MANT_W / EXP_W : field widths of the unpacked result
//   EXP_BIAS                : IEEE-754 single-precision exponent bias
//   conv_res_t              : {sign, reduced mantissa, signed scale exponent}
package fp_conv_pkg;

    localparam int FRAC_W   = 23;
    localparam int MANT_W   = 24;
    localparam int EXP_W    = 9;
    localparam int EXP_BIAS = 127;

    typedef struct packed {
        logic              sign;
        logic [MANT_W-1:0] mant;
        logic [EXP_W-1:0]  exp;
    } conv_res_t;

endpackage

// File: rtl/fp_conv_sched_if.sv
// Requester and result streams of the conversion scheduler.
//   req_valid/req_data/req_ready : N_REQ valid/ready requesters, 32 bits each
//   out_valid/out_ready          : result stream handshake
//   out_sign/out_mant/out_exp    : unpacked result, value = (-1)^s * mant * 2^exp
//   out_tag                      : index of the requester that produced the result
// slave is the scheduler side, master is the requester/consumer side.
interface fp_conv_sched_if #(
    parameter int N_REQ = 4,
    parameter int TAG_W = $clog2(N_REQ)
);
    import fp_conv_pkg::*;

    logic [N_REQ-1:0]    req_valid;
    logic [32*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic                out_valid;
    logic                out_ready;
    logic                out_sign;
    logic [MANT_W-1:0]   out_mant;
    logic [EXP_W-1:0]    out_exp;
    logic [TAG_W-1:0]    out_tag;

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_sign, out_mant, out_exp, out_tag
    );

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_sign, out_mant, out_exp, out_tag
    );

endinterface

// File: rtl/fp_unpack_core.sv
// Combinational unpack of an IEEE-754 single into sign, odd mantissa and scale.
//   a   : 32-bit input word
//   res : {sign, mant, exp}; trailing zeros of the fraction are stripped so the
//         mantissa is the smallest integer representing the value.
// Exponent codes 0 and 255 are treated like normal numbers.
module fp_unpack_core
    import fp_conv_pkg::*;
(
    input  logic [31:0] a,
    output conv_res_t   res
);

    logic [7:0]        e;
    logic [FRAC_W-1:0] f;
    logic [4:0]        tz;
    logic [9:0]        exp_full;

    always_comb begin
        e  = a[30:23];
        f  = a[22:0];
        // Lowest set fraction bit; 23 means only the implicit one is set.
        tz = 5'd23;
        for (int i = FRAC_W - 1; i >= 0; i--) begin
            if (f[i]) tz = 5'(i);
        end
        // e - bias - (23 - tz), evaluated in 10 bits then truncated
        exp_full = {2'b00, e} + {5'b00000, tz} - 10'(EXP_BIAS + FRAC_W);

        res.sign = a[31];
        if (a[30:0] == 31'd0) begin
            res.mant = '0;
            res.exp  = '0;
        end else begin
            res.mant = {1'b1, f} >> tz;
            res.exp  = exp_full[EXP_W-1:0];
        end
    end

endmodule

// File: rtl/fp_conv_sched.sv
// Round-robin scheduler sharing one unpack core among N_REQ requesters.
//   clk, rst : clock and synchronous active-high reset
//   bus      : requester streams in, result stream out (slave side)
//   busy     : either pipeline stage holds valid data
// Pipeline: S1 captures the granted word, the core sits between S1 and S2,
// S2 drives the result stream. A stage advances when it is empty or the
// stage after it advances, so pop and accept can overlap at full rate.
module fp_conv_sched
    import fp_conv_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int TAG_W = $clog2(N_REQ)
) (
    input  logic            clk,
    input  logic            rst,
    fp_conv_sched_if.slave  bus,
    output logic            busy
);

    logic             v1, v2;
    logic             adv1, adv2;
    logic [31:0]      s1_data;
    logic [TAG_W-1:0] s1_tag;
    logic [TAG_W-1:0] rr;
    conv_res_t        core_res;
    conv_res_t        s2_res;
    logic [TAG_W-1:0] s2_tag;

    logic             grant_any;
    logic [TAG_W-1:0] grant_idx;
    logic [TAG_W-1:0] rr_next;
    logic [31:0]      grant_data;
    logic [N_REQ-1:0] ready;

    assign adv2 = !v2 || bus.out_ready;
    assign adv1 = !v1 || adv2;

    // Search starts at rr and wraps; the first valid requester wins.
    always_comb begin
        int k;
        k          = 0;
        grant_any  = 1'b0;
        grant_idx  = '0;
        rr_next    = rr;
        grant_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            k = (int'(rr) + i) % N_REQ;
            if (!grant_any && bus.req_valid[k]) begin
                grant_any  = 1'b1;
                grant_idx  = TAG_W'(k);
                rr_next    = TAG_W'((k + 1) % N_REQ);
                grant_data = bus.req_data[32*k +: 32];
            end
        end
        ready = '0;
        if (grant_any && adv1) ready[grant_idx] = 1'b1;
    end

    fp_unpack_core u_core (
        .a   (s1_data),
        .res (core_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            rr      <= '0;
            s1_data <= '0;
            s1_tag  <= '0;
            s2_res  <= '0;
            s2_tag  <= '0;
        end else begin
            if (adv2) begin
                v2     <= v1;
                s2_res <= core_res;
                s2_tag <= s1_tag;
            end
            if (adv1) begin
                v1 <= grant_any;
                if (grant_any) begin
                    s1_data <= grant_data;
                    s1_tag  <= grant_idx;
                    rr      <= rr_next;
                end
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.out_valid = v2;
    assign bus.out_sign  = s2_res.sign;
    assign bus.out_mant  = s2_res.mant;
    assign bus.out_exp   = s2_res.exp;
    assign bus.out_tag   = s2_tag;
    assign busy          = v1 || v2;

endmodule

// File: tb/tb_fp_conv_sched.sv
// Self-checking bench for fp_conv_sched with four requesters.
module tb_fp_conv_sched;
    import fp_conv_pkg::*;

    localparam int N = 4;

    typedef struct packed {
        logic        sign;
        logic [23:0] mant;
        logic [8:0]  exp;
    } ref_t;

    typedef struct packed {
        logic [1:0]  tag;
        logic [31:0] word;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    fp_conv_sched_if #(.N_REQ(N), .TAG_W(2)) bus ();

    fp_conv_sched #(.N_REQ(N), .TAG_W(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Value-level model: strip factors of two from the full significand.
    function automatic ref_t ref_unpack(input logic [31:0] a);
        ref_t   r;
        longint m;
        int     x;
        r.sign = a[31];
        if (a[30:0] == 31'd0) begin
            r.mant = '0;
            r.exp  = '0;
            return r;
        end
        m = longint'({1'b1, a[22:0]});
        x = int'(a[30:23]) - 150;
        while (m % 2 == 0) begin
            m = m / 2;
            x = x + 1;
        end
        r.mant = 24'(m);
        r.exp  = 9'(x);
        return r;
    endfunction

    function automatic logic [31:0] gen_word();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 7) == 0) w[30:0] = '0;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [31:0] w);
        bus.req_data[32*k +: 32] = w;
        bus.req_valid[k] = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if ({bus.out_valid, busy, bus.req_ready} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got valid=%b busy=%b ready=%b want 0 0 0000",
                     bus.out_valid, busy, bus.req_ready);
        end
        n_checks++;
        if ({bus.out_sign, bus.out_mant, bus.out_exp, bus.out_tag} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_data: got s=%b m=%h e=%h t=%0d want all zero",
                     bus.out_sign, bus.out_mant, bus.out_exp, bus.out_tag);
        end
    endtask

    task automatic test_single_values();
        logic [31:0] words [4] = '{32'h3F800000, 32'h3FC00000, 32'hC0C00000, 32'h80000000};
        ref_t        want  [4] = '{'{1'b0, 24'h000001, 9'h000},
                                   '{1'b0, 24'h000003, 9'h1FF},
                                   '{1'b1, 24'h000003, 9'h001},
                                   '{1'b1, 24'h000000, 9'h000}};
        int          reqs  [4] = '{2, 1, 3, 0};
        logic [3:0]  er;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.req_valid = '0;
            set_req(reqs[i], words[i]);
            bus.out_ready = 1'b1;
            er = 4'(1 << reqs[i]);
            #1;
            n_checks++;
            if (bus.req_ready !== er) begin
                n_fail++;
                $display("FAIL single_ready[%0d]: got %b want %b", i, bus.req_ready, er);
            end
            tick();
            bus.req_valid = '0;
            n_checks++;
            if ({bus.out_valid, busy} !== 2'b01) begin
                n_fail++;
                $display("FAIL single_latency[%0d]: got valid=%b busy=%b want 0 1",
                         i, bus.out_valid, busy);
            end
            tick();
            n_checks++;
            if ({bus.out_valid, bus.out_sign, bus.out_mant, bus.out_exp, bus.out_tag}
                !== {1'b1, want[i], 2'(reqs[i])}) begin
                n_fail++;
                $display("FAIL single_result[%0d]: got v=%b s=%b m=%h e=%h t=%0d want v=1 s=%b m=%h e=%h t=%0d",
                         i, bus.out_valid, bus.out_sign, bus.out_mant, bus.out_exp, bus.out_tag,
                         want[i].sign, want[i].mant, want[i].exp, reqs[i]);
            end
            tick();
            n_checks++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL single_pop[%0d]: got valid=%b want 0", i, bus.out_valid);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] cur  [N];
        logic [31:0] sent [16];
        logic [3:0]  er;
        ref_t        r;
        do_reset();
        for (int k = 0; k < N; k++) begin
            cur[k] = gen_word();
            set_req(k, cur[k]);
        end
        for (int c = 0; c < 16; c++) begin
            er = 4'(1 << (c % N));
            #1;
            n_checks++;
            if (bus.req_ready !== er) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %b want %b", c, bus.req_ready, er);
            end
            sent[c] = cur[c % N];
            tick();
            cur[c % N] = gen_word();
            set_req(c % N, cur[c % N]);
            if (c == 0) begin
                n_checks++;
                if (bus.out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rr_first: got valid=%b want 0", bus.out_valid);
                end
            end else begin
                r = ref_unpack(sent[c-1]);
                n_checks++;
                if ({bus.out_valid, bus.out_sign, bus.out_mant, bus.out_exp, bus.out_tag}
                    !== {1'b1, r, 2'((c - 1) % N)}) begin
                    n_fail++;
                    $display("FAIL rr_out[%0d]: got v=%b t=%0d m=%h e=%h want v=1 t=%0d m=%h e=%h",
                             c, bus.out_valid, bus.out_tag, bus.out_mant, bus.out_exp,
                             (c - 1) % N, r.mant, r.exp);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w0, wa, wb;
        logic [3:0]  er;
        ref_t        r;
        int          accepts;
        do_reset();
        w0 = gen_word();
        set_req(0, w0);
        tick();
        bus.req_valid = '0;
        tick();
        n_checks++;
        if ({bus.out_valid, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL bp_setup: got valid=%b busy=%b want 1 1", bus.out_valid, busy);
        end
        bus.out_ready = 1'b0;
        wa = gen_word();
        wb = gen_word();
        set_req(0, wa);
        set_req(1, wb);
        accepts = 0;
        r = ref_unpack(w0);
        for (int c = 0; c < 5; c++) begin
            er = (c == 0) ? 4'b0010 : 4'b0000;
            #1;
            n_checks++;
            if (bus.req_ready !== er) begin
                n_fail++;
                $display("FAIL bp_ready[%0d]: got %b want %b", c, bus.req_ready, er);
            end
            if ((bus.req_ready & bus.req_valid) != 4'b0000) accepts++;
            tick();
            n_checks++;
            if ({bus.out_valid, bus.out_sign, bus.out_mant, bus.out_exp, bus.out_tag}
                !== {1'b1, r, 2'd0}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b t=%0d m=%h e=%h want v=1 t=0 m=%h e=%h",
                         c, bus.out_valid, bus.out_tag, bus.out_mant, bus.out_exp, r.mant, r.exp);
            end
        end
        n_checks++;
        if (accepts !== 1) begin
            n_fail++;
            $display("FAIL bp_accepts: got %0d want 1", accepts);
        end
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        tick();
        r = ref_unpack(wb);
        n_checks++;
        if ({bus.out_valid, bus.out_sign, bus.out_mant, bus.out_exp, bus.out_tag}
            !== {1'b1, r, 2'd1}) begin
            n_fail++;
            $display("FAIL bp_drain: got v=%b t=%0d m=%h e=%h want v=1 t=1 m=%h e=%h",
                     bus.out_valid, bus.out_tag, bus.out_mant, bus.out_exp, r.mant, r.exp);
        end
        tick();
        n_checks++;
        if ({bus.out_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL bp_empty: got valid=%b busy=%b want 0 0", bus.out_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] cur [N];
        ref_t        r;
        do_reset();
        for (int k = 0; k < N; k++) begin
            cur[k] = gen_word();
            set_req(k, cur[k]);
        end
        tick();
        tick();
        tick();
        n_checks++;
        if ({bus.out_valid, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL mid_pre: got valid=%b busy=%b want 1 1", bus.out_valid, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({bus.out_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_flush: got valid=%b busy=%b want 0 0", bus.out_valid, busy);
        end
        #1;
        n_checks++;
        if (bus.req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL mid_grant: got %b want 0001", bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        tick();
        r = ref_unpack(cur[0]);
        n_checks++;
        if ({bus.out_valid, bus.out_sign, bus.out_mant, bus.out_exp, bus.out_tag}
            !== {1'b1, r, 2'd0}) begin
            n_fail++;
            $display("FAIL mid_first: got v=%b t=%0d m=%h want v=1 t=0 m=%h",
                     bus.out_valid, bus.out_tag, bus.out_mant, r.mant);
        end
    endtask

    task automatic test_random();
        item_t       q[$];
        item_t       it;
        logic [31:0] cur [N];
        logic        vld [N];
        logic [3:0]  er;
        ref_t        r;
        int          rr_m;
        int          g;
        logic        can;
        logic        pop;
        do_reset();
        rr_m = 0;
        for (int k = 0; k < N; k++) vld[k] = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < N; k++) begin
                if (!vld[k]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        vld[k] = 1'b1;
                        cur[k] = gen_word();
                    end
                end else if ($urandom_range(0, 9) == 0) begin
                    vld[k] = 1'b0;
                end
                bus.req_valid[k] = vld[k];
                bus.req_data[32*k +: 32] = cur[k];
            end
            bus.out_ready = (cyc % 64 < 16) ? ($urandom_range(0, 3) == 0)
                                             : ($urandom_range(0, 3) != 0);
            #1;
            // Two-entry pipeline: room for one more unless full and not draining.
            can = (q.size() < 2) || bus.out_ready;
            g = -1;
            if (can) begin
                for (int i = 0; i < N; i++) begin
                    int k = (rr_m + i) % N;
                    if (g < 0 && vld[k]) g = k;
                end
            end
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            n_checks++;
            if (bus.req_ready !== er) begin
                n_fail++;
                $display("FAIL rnd_ready[%0d]: got %b want %b", cyc, bus.req_ready, er);
            end
            if (q.size() == 0) begin
                n_checks++;
                if (bus.out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd_spurious[%0d]: got valid=%b want 0", cyc, bus.out_valid);
                end
            end else if (q.size() == 2) begin
                n_checks++;
                if (bus.out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rnd_stall[%0d]: got valid=%b want 1", cyc, bus.out_valid);
                end
            end
            pop = bus.out_valid && bus.out_ready;
            if (pop && q.size() > 0) begin
                it = q.pop_front();
                r = ref_unpack(it.word);
                n_checks++;
                if ({bus.out_sign, bus.out_mant, bus.out_exp, bus.out_tag} !== {r, it.tag}) begin
                    n_fail++;
                    $display("FAIL rnd_data[%0d]: got t=%0d s=%b m=%h e=%h want t=%0d s=%b m=%h e=%h",
                             cyc, bus.out_tag, bus.out_sign, bus.out_mant, bus.out_exp,
                             it.tag, r.sign, r.mant, r.exp);
                end
            end
            if (g >= 0) begin
                q.push_back('{tag: 2'(g), word: cur[g]});
                rr_m = (g + 1) % N;
                vld[g] = 1'b0;
            end
            tick();
        end
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10 && (q.size() > 0 || bus.out_valid); c++) begin
            #1;
            if (bus.out_valid) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rnd_extra: got tag=%0d want no output", bus.out_tag);
                end else begin
                    it = q.pop_front();
                    r = ref_unpack(it.word);
                    if ({bus.out_sign, bus.out_mant, bus.out_exp, bus.out_tag} !== {r, it.tag}) begin
                        n_fail++;
                        $display("FAIL rnd_drain: got t=%0d m=%h e=%h want t=%0d m=%h e=%h",
                                 bus.out_tag, bus.out_mant, bus.out_exp, it.tag, r.mant, r.exp);
                    end
                end
            end
            tick();
        end
        n_checks++;
        if (q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_final: got %0d undelivered busy=%b want 0 0", q.size(), busy);
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_single_values();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
